lisnoc_router_tdma_sched: RTL and testbench

Time-division scheduler for one router output port in the time-triggered NoC. It sits between the per-input request lines and the output FIFO write side and decides which input port may move flits in each cycle. A configurable cyclic slot table reserves slots for one owning input port; free slots and idle owned slots are shared round-robin. Packets are kept wormhole-atomic: once a header is granted, that port keeps the output until its LAST flit.

---
 rtl/lisnoc_router_tdma_sched_if.sv | 23 ++
 rtl/lisnoc_router_tdma_sched.sv | 163 ++++++++++++++++
 tb/tb_lisnoc_router_tdma_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lisnoc_router_tdma_sched_if.sv
// Flit-movement handshake between the input ports, the TDMA scheduler and the output FIFO write side.
// The master side presents requests and FIFO readiness. The slave (scheduler) side returns the grant.
interface lisnoc_router_tdma_sched_if #(
    parameter int ports           = 5,
    parameter int flit_type_width = 2
);
    logic [ports-1:0]                 request_i;
    logic [flit_type_width*ports-1:0] flit_type_i;
    logic                             ready_i;
    logic [ports-1:0]                 read_o;
    logic                             valid_o;
    logic [$clog2(ports)-1:0]         sel_o;

    modport master (
        output request_i, flit_type_i, ready_i,
        input  read_o, valid_o, sel_o
    );

    modport slave (
        input  request_i, flit_type_i, ready_i,
        output read_o, valid_o, sel_o
    );
endinterface

// File: rtl/lisnoc_router_tdma_sched.sv
// TDMA output-port scheduler: a cyclic slot table reserves slots for owner ports, and other traffic is shared round-robin.
// Once a header is granted, the packet keeps the output until its last flit, so packets are never interleaved.
module lisnoc_router_tdma_sched #(
    parameter int ports           = 5,
    parameter int slots           = 8,
    parameter int slot_len_width  = 8,
    parameter int flit_type_width = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    lisnoc_router_tdma_sched_if.slave  bus,
    input  logic                       cfg_we_i,
    input  logic [$clog2(slots)-1:0]   cfg_addr_i,
    input  logic                       cfg_en_i,
    input  logic [$clog2(ports)-1:0]   cfg_port_i,
    input  logic                       cfg_len_we_i,
    input  logic [slot_len_width-1:0]  cfg_len_i,
    input  logic                       sync_i,
    output logic [$clog2(slots)-1:0]   slot_o
);
    localparam int PW = $clog2(ports);
    localparam int SW = $clog2(slots);

    localparam logic [flit_type_width-1:0] FT_HEADER = flit_type_width'(1);
    localparam logic [flit_type_width-1:0] FT_LAST   = flit_type_width'(2);
    localparam logic [flit_type_width-1:0] FT_SINGLE = flit_type_width'(3);

    typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

    lock_state_e               lockState_q, lockState_d;
    logic [PW-1:0]             lockPort_q, lockPort_d;
    logic [PW-1:0]             rrLast_q, rrLast_d;
    logic [slot_len_width-1:0] cycCnt_q, cycCnt_d;
    logic [slot_len_width-1:0] slotLen_q, slotLen_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic                      tblEn_q   [slots];
    logic                      tblEn_d   [slots];
    logic [PW-1:0]             tblPort_q [slots];
    logic [PW-1:0]             tblPort_d [slots];

    logic                       ownerValid;
    logic [PW-1:0]              gntPort;
    logic                       gntValid;
    logic                       gntByRr;
    logic [PW-1:0]              rrCand;
    logic [flit_type_width-1:0] gntType;
    logic                       transfer;
    logic [slot_len_width-1:0]  effLen;
    logic                       slotEnd;

    // Priority: held lock, then owner of the current slot, then round-robin after rrLast.
    always_comb begin
        ownerValid = tblEn_q[slot_q] && (int'(tblPort_q[slot_q]) < ports);
        gntPort    = '0;
        gntValid   = 1'b0;
        gntByRr    = 1'b0;
        rrCand     = '0;
        if (lockState_q == LOCK_HELD) begin
            gntPort  = lockPort_q;
            gntValid = bus.request_i[lockPort_q];
        end else if (ownerValid && bus.request_i[tblPort_q[slot_q]]) begin
            gntPort  = tblPort_q[slot_q];
            gntValid = 1'b1;
        end else begin
            for (int i = 1; i <= ports; i++) begin
                rrCand = PW'((int'(rrLast_q) + i) % ports);
                if (!gntValid && bus.request_i[rrCand]) begin
                    gntPort  = rrCand;
                    gntValid = 1'b1;
                    gntByRr  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gntType = '0;
        for (int p = 0; p < ports; p++) begin
            if (gntPort == PW'(p)) begin
                gntType = bus.flit_type_i[p*flit_type_width +: flit_type_width];
            end
        end
    end

    // Gating with rst_n keeps the strobes quiet for the whole reset period, even before state is known.
    assign transfer    = rst_n && bus.ready_i && gntValid;
    assign bus.valid_o = transfer;
    assign bus.sel_o   = transfer ? gntPort : '0;

    always_comb begin
        bus.read_o = '0;
        for (int p = 0; p < ports; p++) begin
            bus.read_o[p] = transfer && (gntPort == PW'(p));
        end
    end

    assign effLen  = (slotLen_q == '0) ? slot_len_width'(1) : slotLen_q;
    assign slotEnd = (cycCnt_q >= effLen - slot_len_width'(1));
    assign slot_o  = slot_q;

    always_comb begin
        lockState_d = lockState_q;
        lockPort_d  = lockPort_q;
        rrLast_d    = rrLast_q;
        cycCnt_d    = cycCnt_q + slot_len_width'(1);
        slot_d      = slot_q;
        slotLen_d   = slotLen_q;
        tblEn_d     = tblEn_q;
        tblPort_d   = tblPort_q;

        if (transfer) begin
            if (gntType == FT_HEADER) begin
                lockState_d = LOCK_HELD;
                lockPort_d  = gntPort;
            end else if (gntType == FT_LAST || gntType == FT_SINGLE) begin
                lockState_d = LOCK_IDLE;
            end
            if (gntByRr) begin
                rrLast_d = gntPort;
            end
        end

        if (sync_i) begin
            cycCnt_d = '0;
            slot_d   = '0;
        end else if (slotEnd) begin
            cycCnt_d = '0;
            slot_d   = slot_q + SW'(1);
        end

        if (cfg_we_i) begin
            tblEn_d[cfg_addr_i]   = cfg_en_i;
            tblPort_d[cfg_addr_i] = cfg_port_i;
        end
        if (cfg_len_we_i) begin
            slotLen_d = cfg_len_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lockState_q <= LOCK_IDLE;
            lockPort_q  <= '0;
            rrLast_q    <= PW'(ports - 1);
            cycCnt_q    <= '0;
            slot_q      <= '0;
            slotLen_q   <= slot_len_width'(1);
            for (int s = 0; s < slots; s++) begin
                tblEn_q[s]   <= 1'b0;
                tblPort_q[s] <= '0;
            end
        end else begin
            lockState_q <= lockState_d;
            lockPort_q  <= lockPort_d;
            rrLast_q    <= rrLast_d;
            cycCnt_q    <= cycCnt_d;
            slot_q      <= slot_d;
            slotLen_q   <= slotLen_d;
            tblEn_q     <= tblEn_d;
            tblPort_q   <= tblPort_d;
        end
    end
endmodule

// File: tb/tb_lisnoc_router_tdma_sched.sv
// Scoreboard bench for the TDMA scheduler: the driver pushes the reference model's expectations into a queue, and a negedge monitor pops each expectation and compares it against the DUT.
// The stimulus consists of directed scenarios followed by a randomized run.
module tb_lisnoc_router_tdma_sched;
    localparam int PORTS = 5;
    localparam int SLOTS = 8;
    localparam int LENW  = 8;
    localparam int FTW   = 2;
    localparam int PW    = 3;
    localparam int SW    = 3;

    localparam bit [1:0] FT_PAYLOAD = 2'b00;
    localparam bit [1:0] FT_HEADER  = 2'b01;
    localparam bit [1:0] FT_LAST    = 2'b10;
    localparam bit [1:0] FT_SINGLE  = 2'b11;
    localparam bit [FTW*PORTS-1:0] ALL_SINGLE = {PORTS{2'b11}};

    logic            clk = 1'b1;
    logic            rst_n;
    logic            cfg_we, cfg_en, cfg_len_we, sync;
    logic [SW-1:0]   cfg_addr;
    logic [PW-1:0]   cfg_port;
    logic [LENW-1:0] cfg_len;
    logic [SW-1:0]   slot;

    always #5 clk = ~clk;

    lisnoc_router_tdma_sched_if #(.ports(PORTS), .flit_type_width(FTW)) bus ();

    lisnoc_router_tdma_sched #(
        .ports(PORTS), .slots(SLOTS), .slot_len_width(LENW), .flit_type_width(FTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_en_i     (cfg_en),
        .cfg_port_i   (cfg_port),
        .cfg_len_we_i (cfg_len_we),
        .cfg_len_i    (cfg_len),
        .sync_i       (sync),
        .slot_o       (slot)
    );

    typedef struct packed {
        bit                 rstn;
        bit [PORTS-1:0]     req;
        bit [FTW*PORTS-1:0] ft;
        bit                 ready;
        bit                 cfgWe;
        bit [SW-1:0]        cfgAddr;
        bit                 cfgEn;
        bit [PW-1:0]        cfgPort;
        bit                 cfgLenWe;
        bit [LENW-1:0]      cfgLen;
        bit                 sync;
    } stim_t;

    typedef struct packed {
        bit [PORTS-1:0] read;
        bit             valid;
        bit [PW-1:0]    sel;
        bit [SW-1:0]    slot;
        bit             chkSlot;
    } exp_t;

    exp_t expQ[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: plain integers, with -1 meaning "no lock".
    int mCyc, mSlot, mLen, mLock, mRr;
    int mTblEn   [SLOTS];
    int mTblPort [SLOTS];
    bit mKnown = 1'b0;

    function automatic exp_t modelStep(input stim_t s);
        exp_t   e;
        int     owner, g, eff;
        bit     byRr;
        bit [1:0] t;
        e         = '0;
        e.chkSlot = mKnown;
        e.slot    = SW'(mSlot);
        if (!s.rstn) begin
            mCyc = 0; mSlot = 0; mLen = 1; mLock = -1; mRr = PORTS - 1;
            for (int i = 0; i < SLOTS; i++) begin
                mTblEn[i]   = 0;
                mTblPort[i] = 0;
            end
            mKnown = 1'b1;
            return e;
        end
        owner = (mTblEn[mSlot] != 0 && mTblPort[mSlot] < PORTS) ? mTblPort[mSlot] : -1;
        g     = -1;
        byRr  = 1'b0;
        if (mLock >= 0) begin
            if (s.req[mLock]) g = mLock;
        end else if (owner >= 0 && s.req[owner]) begin
            g = owner;
        end else begin
            for (int k = 1; k <= PORTS; k++) begin
                int p;
                p = (mRr + k) % PORTS;
                if (g < 0 && s.req[p]) begin
                    g    = p;
                    byRr = 1'b1;
                end
            end
        end
        if (s.ready && g >= 0) begin
            e.read  = PORTS'(1) << g;
            e.valid = 1'b1;
            e.sel   = PW'(g);
            t = s.ft[g*FTW +: FTW];
            if (t == FT_HEADER) mLock = g;
            else if (t == FT_LAST || t == FT_SINGLE) mLock = -1;
            if (byRr) mRr = g;
        end
        eff = (mLen == 0) ? 1 : mLen;
        if (s.sync) begin
            mCyc = 0; mSlot = 0;
        end else if (mCyc >= eff - 1) begin
            mCyc = 0; mSlot = (mSlot + 1) % SLOTS;
        end else begin
            mCyc++;
        end
        if (s.cfgWe) begin
            mTblEn[s.cfgAddr]   = int'(s.cfgEn);
            mTblPort[s.cfgAddr] = int'(s.cfgPort);
        end
        if (s.cfgLenWe) mLen = int'(s.cfgLen);
        return e;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s       = '0;
        s.rstn  = 1'b1;
        s.ready = 1'b1;
        s.ft    = ALL_SINGLE;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst_n           = s.rstn;
        bus.request_i   = s.req;
        bus.flit_type_i = s.ft;
        bus.ready_i     = s.ready;
        cfg_we          = s.cfgWe;
        cfg_addr        = s.cfgAddr;
        cfg_en          = s.cfgEn;
        cfg_port        = s.cfgPort;
        cfg_len_we      = s.cfgLenWe;
        cfg_len         = s.cfgLen;
        sync            = s.sync;
        expQ.push_back(modelStep(s));
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        bit ok;
        vectors++;
        ok = (bus.read_o == e.read) && (bus.valid_o == e.valid) && (bus.sel_o == e.sel) &&
             (!e.chkSlot || slot == e.slot);
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL grant @%0t: got read=%b valid=%b sel=%0d slot=%0d, want read=%b valid=%b sel=%0d slot=%0d",
                     $time, bus.read_o, bus.valid_o, bus.sel_o, slot, e.read, e.valid, e.sel, e.slot);
        end
    endtask

    exp_t monE;
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput(monE);
        end
    end

    task automatic idle(input int n);
        stim_t s;
        s = idleStim();
        repeat (n) applyStimulus(s);
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0; bus.request_i = '0; bus.flit_type_i = '0; bus.ready_i = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_port = '0;
        cfg_len_we = 1'b0; cfg_len = '0; sync = 1'b0;
        #1;

        $display("[TB] reset with all requests high, then round-robin 0,1,2");
        s = idleStim(); s.rstn = 1'b0; s.req = '1;
        repeat (3) applyStimulus(s);
        s = idleStim(); s.req = 5'b00111;
        repeat (3) applyStimulus(s);
        idle(1);

        $display("[TB] owned slot: len 4, slot0 owned by port 3");
        s = idleStim(); s.cfgLenWe = 1'b1; s.cfgLen = 8'd4;
        s.cfgWe = 1'b1; s.cfgAddr = 3'd0; s.cfgEn = 1'b1; s.cfgPort = 3'd3;
        applyStimulus(s);
        s = idleStim(); s.cfgWe = 1'b1; s.cfgAddr = 3'd1; s.cfgEn = 1'b0;
        applyStimulus(s);
        s = idleStim(); s.sync = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.req = 5'b01010;
        repeat (8) applyStimulus(s);

        $display("[TB] wormhole packet from slot 7 into owned slot 0");
        s = idleStim(); s.cfgWe = 1'b1; s.cfgAddr = 3'd0; s.cfgEn = 1'b1; s.cfgPort = 3'd0;
        applyStimulus(s);
        s = idleStim(); s.sync = 1'b1;
        applyStimulus(s);
        idle(31);
        s = idleStim(); s.req = 5'b00100; s.ft[2*FTW +: FTW] = FT_HEADER;
        applyStimulus(s);
        s.req = 5'b00101; s.ft[2*FTW +: FTW] = FT_PAYLOAD;
        repeat (2) applyStimulus(s);
        s.ft[2*FTW +: FTW] = FT_LAST;
        applyStimulus(s);
        s = idleStim(); s.req = 5'b00001;
        repeat (2) applyStimulus(s);

        $display("[TB] backpressure with lock on port 1");
        s = idleStim(); s.req = 5'b00010; s.ft[1*FTW +: FTW] = FT_HEADER;
        applyStimulus(s);
        s.req = 5'b00011; s.ft[1*FTW +: FTW] = FT_PAYLOAD; s.ready = 1'b0;
        repeat (5) applyStimulus(s);
        s.ready = 1'b1;
        applyStimulus(s);
        s.ft[1*FTW +: FTW] = FT_LAST;
        applyStimulus(s);
        s = idleStim(); s.req = 5'b00011;
        repeat (2) applyStimulus(s);

        $display("[TB] sync on last cycle of slot 7, then mid-slot in slot 3");
        s = idleStim(); s.sync = 1'b1;
        applyStimulus(s);
        idle(31);
        applyStimulus(s);
        idle(13);
        applyStimulus(s);
        idle(2);

        $display("[TB] config corners: invalid owner port, zero length");
        s = idleStim(); s.cfgLenWe = 1'b1; s.cfgLen = 8'd16;
        s.cfgWe = 1'b1; s.cfgAddr = 3'd0; s.cfgEn = 1'b1; s.cfgPort = 3'd4;
        applyStimulus(s);
        s = idleStim(); s.sync = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.req = 5'b10010;
        repeat (3) applyStimulus(s);
        s.cfgWe = 1'b1; s.cfgAddr = 3'd0; s.cfgEn = 1'b1; s.cfgPort = 3'd7;
        applyStimulus(s);
        s = idleStim(); s.req = 5'b10010;
        repeat (4) applyStimulus(s);
        s = idleStim(); s.cfgLenWe = 1'b1; s.cfgLen = 8'd0;
        applyStimulus(s);
        idle(10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 800; n++) begin
            s          = idleStim();
            s.rstn     = ($urandom_range(199) != 0);
            s.req      = PORTS'($urandom);
            s.ft       = (FTW*PORTS)'($urandom);
            s.ready    = ($urandom_range(3) != 0);
            s.cfgWe    = ($urandom_range(19) == 0);
            s.cfgAddr  = SW'($urandom_range(SLOTS - 1));
            s.cfgEn    = ($urandom_range(3) != 0);
            s.cfgPort  = PW'($urandom_range(7));
            s.cfgLenWe = ($urandom_range(29) == 0);
            s.cfgLen   = LENW'($urandom_range(5));
            s.sync     = ($urandom_range(49) == 0);
            applyStimulus(s);
        end
        idle(2);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
